master_port_split: RTL and testbench

//  Bus-side master port that initiates transfers to the bit-serial slave ports.

---
 rtl/master_port_split_pkg.sv | 32 +++
 rtl/master_shift_reg.sv | 49 ++++
 rtl/master_port_split.sv | 222 ++++++++++++++++++++++
 tb/tb_master_port_split.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/master_port_split_pkg.sv
// ============================================================================
// master_port_split_pkg : shared state encoding and size defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package master_port_split_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TIMEOUT    = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ADDR  = 3'd2,
    S_WAIT  = 3'd3,
    S_SPLIT = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Counter must be able to hold the full length without wrapping.
  function automatic int bit_cnt_width(input int a_w, input int d_w);
    int m;
    m = (a_w > d_w) ? a_w : d_w;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/master_shift_reg.sv
// ============================================================================
// master_shift_reg : LSB-first shift register, parallel/serial load and read
// Rev 1.0
// ============================================================================
`default_nettype none

module master_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic [WIDTH-1:0] par_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;

  // Serial input enters at the MSB so the first bit received ends up in bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= load_data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q <= {serial_i, sr_q[WIDTH-1:1]};
      if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign serial_o = sr_q[0];
  assign par_o    = sr_q;
  assign cnt_o    = cnt_q;

endmodule

`default_nettype wire

// File: rtl/master_port_split.sv
// ============================================================================
// master_port_split : bus master port, serial address/data out, serial read in
// Rev 1.0
// ============================================================================
`default_nettype none

module master_port_split
  import master_port_split_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  timeout_err,
  output logic                  bus_req,
  input  logic                  bus_grant,
  input  logic                  split_en,
  output logic                  read_en,
  output logic                  write_en,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  slave_ready,
  input  logic                  slave_valid,
  output logic                  tx_address,
  output logic                  tx_data,
  input  logic                  rx_data
);

  localparam int CNT_W = bit_cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  op_read_q, op_read_d;
  logic                  err_q, err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic                  load, tx_shift, rx_shift, tmo_run, tmo_hit;
  logic                  addr_ser, data_ser, rx_ser;
  logic [ADDR_WIDTH-1:0] addr_par;
  logic [DATA_WIDTH-1:0] wdat_par, rx_par;
  logic [CNT_W-1:0]      addr_cnt, wdat_cnt, rx_cnt;
  logic                  unused_ok;

  master_shift_reg #(.WIDTH(ADDR_WIDTH), .CNT_W(CNT_W)) u_addr_tx (
    .clk(clk), .reset(reset), .load_i(load), .load_data_i(address_in),
    .shift_i(tx_shift), .serial_i(1'b0), .serial_o(addr_ser),
    .par_o(addr_par), .cnt_o(addr_cnt)
  );

  master_shift_reg #(.WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_wdat_tx (
    .clk(clk), .reset(reset), .load_i(load), .load_data_i(data_in),
    .shift_i(tx_shift), .serial_i(1'b0), .serial_o(data_ser),
    .par_o(wdat_par), .cnt_o(wdat_cnt)
  );

  master_shift_reg #(.WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_rdat_rx (
    .clk(clk), .reset(reset), .load_i(load), .load_data_i('0),
    .shift_i(rx_shift), .serial_i(rx_data), .serial_o(rx_ser),
    .par_o(rx_par), .cnt_o(rx_cnt)
  );

  assign unused_ok = ^{addr_par, wdat_par, wdat_cnt, rx_ser};
  assign tmo_hit   = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_read_q  <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      op_read_q  <= op_read_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      data_out_q <= data_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_read_d    = op_read_q;
    err_d        = err_q;
    data_out_d   = data_out_q;
    load         = 1'b0;
    tx_shift     = 1'b0;
    rx_shift     = 1'b0;
    tmo_run      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    timeout_err  = 1'b0;
    bus_req      = 1'b0;
    read_en      = 1'b0;
    write_en     = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    tx_address   = 1'b0;
    tx_data      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_read || req_write) begin
          load      = 1'b1;
          op_read_d = req_read;
          err_d     = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_grant) begin
          read_en  = op_read_q;
          write_en = !op_read_q;
          tmo_run  = 1'b1;
          if (slave_ready) begin
            state_d = S_ADDR;
          end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ADDR: begin
        busy         = 1'b1;
        bus_req      = 1'b1;
        read_en      = op_read_q;
        write_en     = !op_read_q;
        master_valid = 1'b1;
        tx_address   = addr_ser;
        tx_data      = data_ser;
        if (!bus_grant) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tx_shift = 1'b1;
          if (addr_cnt == ADDR_LAST) begin
            state_d = op_read_q ? S_WAIT : S_DONE;
          end
        end
      end
      S_WAIT: begin
        busy         = 1'b1;
        bus_req      = 1'b1;
        master_ready = !split_en;
        tmo_run      = 1'b1;
        if (split_en) begin
          state_d = S_SPLIT;
        end else if (slave_valid) begin
          rx_shift = 1'b1;
          state_d  = S_RDATA;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SPLIT: begin
        // Bit 0 is taken in RDATA; the slave holds it until master_ready.
        busy    = 1'b1;
        bus_req = !split_en;
        if (!split_en && bus_grant) begin
          tmo_run = 1'b1;
          if (slave_valid) begin
            state_d = S_RDATA;
          end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RDATA: begin
        busy         = 1'b1;
        bus_req      = 1'b1;
        master_ready = 1'b1;
        if (!bus_grant) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (slave_valid) begin
          rx_shift = 1'b1;
          if (rx_cnt == DATA_LAST) begin
            data_out_d = {rx_data, rx_par[DATA_WIDTH-1:1]};
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        done        = 1'b1;
        timeout_err = err_q;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Timeout measures time spent in the current state only.
    if (state_d != state_q || !tmo_run) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  assign data_out = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_master_port_split.sv
// ============================================================================
// tb_master_port_split : directed checks of master_port_split
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_master_port_split;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write;
  logic [11:0] address_in;
  logic [7:0]  data_in;
  logic        busy, done, timeout_err, bus_req, read_en, write_en;
  logic [7:0]  data_out;
  logic        bus_grant, split_en, master_valid, master_ready;
  logic        slave_ready, slave_valid, tx_address, tx_data, rx_data;

  int n_cmp = 0;
  int n_bad = 0;

  master_port_split dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .address_in(address_in), .data_in(data_in), .busy(busy), .done(done),
    .data_out(data_out), .timeout_err(timeout_err), .bus_req(bus_req),
    .bus_grant(bus_grant), .split_en(split_en), .read_en(read_en),
    .write_en(write_en), .master_valid(master_valid),
    .master_ready(master_ready), .slave_ready(slave_ready),
    .slave_valid(slave_valid), .tx_address(tx_address), .tx_data(tx_data),
    .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [11:0] a, input logic [7:0] d);
    req_read = rd; req_write = wr; address_in = a; data_in = d;
    tick(1);
    req_read = 1'b0; req_write = 1'b0;
  endtask

  // Slave side: present each bit until it is accepted by a valid/ready handshake.
  task automatic slave_send(input logic [7:0] v);
    int  i = 0;
    int  guard = 0;
    logic rdy;
    while (i < 8 && guard < 100) begin
      rx_data = v[i]; slave_valid = 1'b1;
      #1 rdy = master_ready;
      @(negedge clk);
      if (rdy) i++;
      guard++;
    end
    slave_valid = 1'b0; rx_data = 1'b0;
    check_eq("slave_bits_accepted", i, 8);
  endtask

  logic [11:0] av, dv;
  int          mv;

  initial begin
    reset = 1'b1; req_read = 1'b0; req_write = 1'b0; address_in = '0; data_in = '0;
    bus_grant = 1'b1; split_en = 1'b0; slave_ready = 1'b1; slave_valid = 1'b0; rx_data = 1'b0;
    tick(3);
    check_eq("reset_outputs",
             {busy, done, timeout_err, bus_req, read_en, write_en, master_valid,
              master_ready, tx_address, tx_data, data_out}, 0);
    reset = 1'b0;
    tick(1);

    // Write 0x5A3 / 0xC6
    issue(1'b0, 1'b1, 12'h5A3, 8'hC6);
    check_eq("wr_req_phase", {busy, bus_req, write_en, read_en}, 4'b1110);
    av = '0; dv = '0; mv = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      av[k] = tx_address; dv[k] = tx_data; mv += int'(master_valid);
    end
    check_eq("wr_addr_bits", av, 12'h5A3);
    check_eq("wr_data_bits", dv, 12'h0C6);
    check_eq("wr_valid_cycles", mv, 12);
    tick(1);
    check_eq("wr_done", {done, timeout_err, busy}, 3'b100);
    tick(1);
    check_eq("wr_done_1cyc", done, 0);

    // Fast read 0x010 -> 0x9B
    issue(1'b1, 1'b0, 12'h010, 8'h00);
    check_eq("rd_req_strobe", {read_en, write_en}, 2'b10);
    tick(13);
    check_eq("rd_wait_ready", {master_ready, master_valid}, 2'b10);
    slave_send(8'h9B);
    check_eq("rd_done", {done, timeout_err}, 2'b10);
    check_eq("rd_data", data_out, 8'h9B);
    tick(1);

    // Split read -> 0x3C
    issue(1'b1, 1'b0, 12'h7F1, 8'h00);
    tick(13);
    split_en = 1'b1;
    tick(1);
    check_eq("split_release", {busy, bus_req, master_ready}, 3'b100);
    tick(9);
    check_eq("split_held", {bus_req, data_out}, {1'b0, 8'h9B});
    split_en = 1'b0;
    #1 check_eq("split_rereq", bus_req, 1);
    slave_send(8'h3C);
    check_eq("split_done", {done, timeout_err}, 2'b10);
    check_eq("split_data", data_out, 8'h3C);
    tick(1);

    // Timeout: slave never answers
    issue(1'b1, 1'b0, 12'h123, 8'h00);
    tick(13);
    tick(63);
    check_eq("tmo_not_yet", done, 0);
    tick(1);
    check_eq("tmo_done", {done, timeout_err}, 2'b11);
    check_eq("tmo_data_kept", data_out, 8'h3C);
    tick(1);

    // Reset after bit 3 of a read
    issue(1'b1, 1'b0, 12'h0AA, 8'h00);
    tick(13);
    for (int k = 0; k < 4; k++) begin
      rx_data = 1'b1; slave_valid = 1'b1;
      tick(1);
    end
    check_eq("rst_pre_busy", {busy, master_ready}, 2'b11);
    #2 reset = 1'b1;
    #1 check_eq("rst_async_outputs",
                {busy, done, timeout_err, bus_req, read_en, write_en, master_valid,
                 master_ready, tx_address, tx_data, data_out}, 0);
    slave_valid = 1'b0; rx_data = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("rst_no_done", {done, busy}, 0);
    issue(1'b0, 1'b1, 12'h0F0, 8'h55);
    tick(13);
    check_eq("rst_after_write_done", {done, timeout_err}, 2'b10);
    tick(1);

    // Read wins over write; request while busy ignored
    issue(1'b1, 1'b1, 12'h321, 8'h11);
    check_eq("both_read_wins", {read_en, write_en}, 2'b10);
    tick(3);
    req_write = 1'b1; address_in = 12'hFFF; data_in = 8'hFF;
    tick(1);
    req_write = 1'b0;
    tick(9);
    slave_send(8'hA7);
    check_eq("both_done", {done, timeout_err}, 2'b10);
    check_eq("both_data", data_out, 8'hA7);
    tick(1);
    check_eq("busy_req_ignored", {busy, bus_req}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
